// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ requesters.
// Latency: request -> start strobe 2 cycles; frame-done -> ack 1 cycle; watchdog aborts after TIMEOUT+1 cycles.
// Backpressure: one frame at a time; requesters hold in_req until their ack, unserved requesters wait.
//
// Ports:
//   in_clk, in_rst       clock, asynchronous active-low reset
//   in_req, in_data      per-requester level request and word (requester i at [i*WORD_W +: WORD_W])
//   out_ack, out_err     one-cycle completion pulse per requester / watchdog abort pulse
//   out_grant_id         index of current or last granted requester
//   out_busy             high whenever the sequencer is not idle
//   out_mem, out_utx_st  word and start strobe to the transmitter
//   in_utx_bs, in_utx_rd transmitter busy (status only) and frame-done pulse
module uart_tx_arb #(
    parameter int N_REQ   = 4,
    parameter int WORD_W  = 6,
    parameter int TIMEOUT = 4095,
    parameter int CNT_W   = 12
) (
    input  logic                      in_clk,
    input  logic                      in_rst,
    input  logic [N_REQ-1:0]          in_req,
    input  logic [N_REQ*WORD_W-1:0]   in_data,
    output logic [N_REQ-1:0]          out_ack,
    output logic                      out_err,
    output logic [2:0]                out_grant_id,
    output logic                      out_busy,
    output logic [WORD_W-1:0]         out_mem,
    output logic                      out_utx_st,
    input  logic                      in_utx_bs,
    input  logic                      in_utx_rd
);

    localparam int GID_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE
    } state_t;

    state_t              r_state;
    logic [GID_W-1:0]    r_last;
    logic [GID_W-1:0]    r_grant;
    logic [WORD_W-1:0]   r_mem;
    logic [CNT_W-1:0]    r_wd;
    logic [N_REQ-1:0]    r_ack;
    logic                r_err;
    logic                r_busy;
    logic                r_st;

    logic [GID_W-1:0]    w_sel;
    logic [WORD_W-1:0]   w_word;
    int                  w_idx;

    // Transmitter busy is informational only; sequencing relies on the frame-done pulse.
    logic                w_unused;
    assign w_unused = in_utx_bs;

    // Round-robin pick: scan last+N_REQ down to last+1 so the nearest set bit after
    // the last grant is the final (winning) assignment.
    always_comb begin
        w_sel = '0;
        w_idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (((in_req >> w_idx) & N_REQ'(1)) != '0) begin
                w_sel = GID_W'(w_idx);
            end
        end
        w_word = WORD_W'(in_data >> (int'(w_sel) * WORD_W));
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= S_IDLE;
            r_last  <= GID_W'(N_REQ - 1);
            r_grant <= '0;
            r_mem   <= '0;
            r_wd    <= '0;
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_st    <= 1'b0;
        end else begin
            r_st  <= 1'b0;
            r_ack <= '0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|in_req) begin
                        r_mem   <= w_word;
                        r_grant <= w_sel;
                        r_busy  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // Word was latched one cycle earlier, so it is stable when the strobe rises.
                    r_st    <= 1'b1;
                    r_wd    <= '0;
                    r_state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    r_wd <= r_wd + CNT_W'(1);
                    // Frame-done takes precedence over a simultaneous watchdog expiry.
                    if (in_utx_rd) begin
                        r_ack   <= N_REQ'(1) << r_grant;
                        r_last  <= r_grant;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_wd == CNT_W'(TIMEOUT)) begin
                        // Abort without ack; requester stays pending but loses priority.
                        r_err   <= 1'b1;
                        r_last  <= r_grant;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_ack      = r_ack;
    assign out_err      = r_err;
    assign out_grant_id = r_grant;
    assign out_busy     = r_busy;
    assign out_mem      = r_mem;
    assign out_utx_st   = r_st;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: table of round-robin grants plus hand sequences
// for latency, watchdog, simultaneous done/timeout, async reset and data stability.
// Transmitter is modelled by pulsing in_utx_rd a chosen number of cycles after the strobe.
module tb_uart_tx_arb;

    localparam int N_REQ   = 4;
    localparam int WORD_W  = 6;
    localparam int TIMEOUT = 4095;
    localparam int CNT_W   = 12;

    logic                    clk;
    logic                    in_rst;
    logic [N_REQ-1:0]        in_req;
    logic [N_REQ*WORD_W-1:0] in_data;
    logic [N_REQ-1:0]        out_ack;
    logic                    out_err;
    logic [2:0]              out_grant_id;
    logic                    out_busy;
    logic [WORD_W-1:0]       out_mem;
    logic                    out_utx_st;
    logic                    in_utx_bs;
    logic                    in_utx_rd;

    int errors = 0;
    int checks = 0;

    uart_tx_arb #(
        .N_REQ   (N_REQ),
        .WORD_W  (WORD_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .in_clk       (clk),
        .in_rst       (in_rst),
        .in_req       (in_req),
        .in_data      (in_data),
        .out_ack      (out_ack),
        .out_err      (out_err),
        .out_grant_id (out_grant_id),
        .out_busy     (out_busy),
        .out_mem      (out_mem),
        .out_utx_st   (out_utx_st),
        .in_utx_bs    (in_utx_bs),
        .in_utx_rd    (in_utx_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic [N_REQ-1:0] req;
        logic [2:0]       gid;
        logic [WORD_W-1:0] mem;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the start strobe; an expired bound shows up as a failed check.
    task automatic wait_st(input string name);
        for (int n = 0; n < 10 && !out_utx_st; n++) begin
            tick();
        end
        check({name, "_strobe"}, {31'd0, out_utx_st}, 32'd1);
    endtask

    // One complete frame: strobe, grant/word check, frame-done after d cycles, ack check.
    task automatic do_frame(input string name, input logic [2:0] gid,
                            input logic [WORD_W-1:0] mem, input int d);
        wait_st(name);
        check({name, "_gid"}, {29'd0, out_grant_id}, {29'd0, gid});
        check({name, "_mem"}, {26'd0, out_mem}, {26'd0, mem});
        in_utx_bs = 1'b1;
        repeat (d) tick();
        in_utx_rd = 1'b1;
        tick();
        in_utx_rd = 1'b0;
        in_utx_bs = 1'b0;
        check({name, "_ack"}, {28'd0, out_ack}, {28'd0, 4'(4'b0001 << gid)});
        check({name, "_err"}, {31'd0, out_err}, 32'd0);
        check({name, "_idle"}, {31'd0, out_busy}, 32'd0);
    endtask

    initial begin
        int  cnt;
        logic ack_seen;

        vecs[0]  = '{4'b1111, 3'd1, 6'h02};
        vecs[1]  = '{4'b1111, 3'd2, 6'h03};
        vecs[2]  = '{4'b1111, 3'd3, 6'h04};
        vecs[3]  = '{4'b1111, 3'd0, 6'h01};
        vecs[4]  = '{4'b1111, 3'd1, 6'h02};
        vecs[5]  = '{4'b0101, 3'd2, 6'h03};
        vecs[6]  = '{4'b0101, 3'd0, 6'h01};
        vecs[7]  = '{4'b1001, 3'd3, 6'h04};
        vecs[8]  = '{4'b1001, 3'd0, 6'h01};
        vecs[9]  = '{4'b0110, 3'd1, 6'h02};
        vecs[10] = '{4'b0001, 3'd0, 6'h01};

        in_rst    = 1'b0;
        in_req    = '0;
        in_data   = '0;
        in_utx_bs = 1'b0;
        in_utx_rd = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, out_busy},   32'd0);
        check("rst_st",   {31'd0, out_utx_st}, 32'd0);
        check("rst_mem",  {26'd0, out_mem},    32'd0);
        check("rst_gid",  {29'd0, out_grant_id}, 32'd0);
        check("rst_ack",  {28'd0, out_ack},    32'd0);
        check("rst_err",  {31'd0, out_err},    32'd0);
        #3 in_rst = 1'b1;
        tick();

        // Single request: word latched after one edge, strobe on the second
        in_data[0 +: WORD_W] = 6'h2A;
        in_req = 4'b0001;
        tick();
        check("single_st_early", {31'd0, out_utx_st}, 32'd0);
        check("single_mem",      {26'd0, out_mem},    32'h2A);
        check("single_busy",     {31'd0, out_busy},   32'd1);
        tick();
        check("single_st",       {31'd0, out_utx_st}, 32'd1);
        check("single_gid",      {29'd0, out_grant_id}, 32'd0);
        in_utx_bs = 1'b1;
        tick();
        check("single_st_pulse", {31'd0, out_utx_st}, 32'd0);
        repeat (4) tick();
        in_utx_rd = 1'b1;
        tick();
        in_utx_rd = 1'b0;
        in_utx_bs = 1'b0;
        in_req    = '0;
        check("single_ack", {28'd0, out_ack}, 32'b0001);
        tick();
        check("single_ack_pulse", {28'd0, out_ack}, 32'd0);

        // Round-robin table
        in_data = {6'h04, 6'h03, 6'h02, 6'h01};
        for (int i = 0; i < 11; i++) begin
            in_req = vecs[i].req;
            do_frame($sformatf("rr%0d", i), vecs[i].gid, vecs[i].mem, 3 + i);
        end
        in_req = '0;

        // Watchdog: no frame-done, err exactly TIMEOUT+1 cycles after the strobe
        tick();
        in_req = 4'b0010;
        wait_st("wd");
        check("wd_gid", {29'd0, out_grant_id}, 32'd1);
        in_utx_bs = 1'b1;
        cnt = 0;
        ack_seen = 1'b0;
        for (int n = 0; n < TIMEOUT + 20; n++) begin
            tick();
            cnt++;
            if (out_ack != '0) ack_seen = 1'b1;
            if (out_err) break;
        end
        in_utx_bs = 1'b0;
        check("wd_latency", cnt, TIMEOUT + 1);
        check("wd_err",     {31'd0, out_err},  32'd1);
        check("wd_no_ack",  {31'd0, ack_seen}, 32'd0);
        check("wd_idle",    {31'd0, out_busy}, 32'd0);
        // Aborted requester 1 stays pending but is served after 3 and 0
        in_req = 4'b1011;
        do_frame("wd_rr_a", 3'd3, 6'h04, 2);
        do_frame("wd_rr_b", 3'd0, 6'h01, 2);
        do_frame("wd_rr_c", 3'd1, 6'h02, 2);

        // Frame-done coincides with watchdog expiry: ack only
        in_req = 4'b0100;
        do_frame("tie", 3'd2, 6'h03, TIMEOUT);
        in_req = '0;
        tick();
        check("tie_err_after", {31'd0, out_err}, 32'd0);

        // Async reset mid WAIT_DONE
        in_req = 4'b1000;
        wait_st("rst_mid");
        check("rst_mid_gid", {29'd0, out_grant_id}, 32'd3);
        repeat (3) tick();
        #2 in_rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, out_busy},   32'd0);
        check("rst_mid_st",   {31'd0, out_utx_st}, 32'd0);
        check("rst_mid_mem",  {26'd0, out_mem},    32'd0);
        check("rst_mid_gid0", {29'd0, out_grant_id}, 32'd0);
        @(posedge clk);
        #3;
        check("rst_mid_ack", {28'd0, out_ack}, 32'd0);
        check("rst_mid_err", {31'd0, out_err}, 32'd0);
        in_req = 4'b1001;
        in_rst = 1'b1;
        tick();
        do_frame("post_rst", 3'd0, 6'h01, 4);

        // Data changed during WAIT_DONE does not disturb the latched word
        in_req = 4'b0010;
        wait_st("hold");
        check("hold_mem0", {26'd0, out_mem}, 32'h02);
        in_data[1*WORD_W +: WORD_W] = 6'h3F;
        repeat (3) tick();
        check("hold_mem1", {26'd0, out_mem}, 32'h02);
        in_utx_rd = 1'b1;
        tick();
        in_utx_rd = 1'b0;
        check("hold_ack",  {28'd0, out_ack}, 32'b0010);
        check("hold_mem2", {26'd0, out_mem}, 32'h02);
        do_frame("hold_next", 3'd1, 6'h3F, 2);

        // Request dropped after grant: ack still pulses, then idle
        in_req = 4'b0100;
        wait_st("drop");
        check("drop_gid", {29'd0, out_grant_id}, 32'd2);
        in_req = '0;
        repeat (4) tick();
        in_utx_rd = 1'b1;
        tick();
        in_utx_rd = 1'b0;
        check("drop_ack", {28'd0, out_ack}, 32'b0100);
        cnt = 0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (out_utx_st || out_busy) cnt++;
        end
        check("drop_idle", cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
